toast_alu_arbiter: RTL and testbench

TOAST_ALU_ARBITER -- requirements
Module: toast_alu_arbiter

---
 rtl/toast_alu_arbiter.sv | 158 +++++++++++++++
 tb/tb_toast_alu_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/toast_alu_arbiter.sv
// Two-requester front end for a single shared combinational ALU.
// One operation is in flight at a time: IDLE grants, EXEC drives the ALU, RESP holds the result.
module toast_alu_arbiter #(
    parameter bit FIXED_PRI = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [3:0]  req0_ctrl_i,
    input  logic [31:0] req0_op1_i,
    input  logic [31:0] req0_op2_i,
    output logic        rsp0_valid_o,
    input  logic        rsp0_ready_i,
    output logic [31:0] rsp0_result_o,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [3:0]  req1_ctrl_i,
    input  logic [31:0] req1_op1_i,
    input  logic [31:0] req1_op2_i,
    output logic        rsp1_valid_o,
    input  logic        rsp1_ready_i,
    output logic [31:0] rsp1_result_o,
    output logic [3:0]  alu_ctrl_o,
    output logic [31:0] alu_op1_o,
    output logic [31:0] alu_op2_o,
    input  logic [31:0] alu_result_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic        owner_r;
    logic        last_grant_r;
    logic        grant_s;
    logic        grant_id_s;
    logic        owner_ready_s;
    logic [3:0]  ctrl_r;
    logic [31:0] op1_r;
    logic [31:0] op2_r;
    logic [31:0] result0_r;
    logic [31:0] result1_r;
    logic        rsp0_valid_r;
    logic        rsp1_valid_r;

    // Grant selection: only in IDLE; ties go to fixed priority or away from the last winner.
    always_comb begin
        grant_s    = 1'b0;
        grant_id_s = 1'b0;
        if ((state_r == IDLE) && (req0_valid_i || req1_valid_i)) begin
            grant_s = 1'b1;
            if (req0_valid_i && req1_valid_i) begin
                grant_id_s = FIXED_PRI ? 1'b0 : ~last_grant_r;
            end else begin
                grant_id_s = req0_valid_i ? 1'b0 : 1'b1;
            end
        end else begin
            grant_s    = 1'b0;
            grant_id_s = 1'b0;
        end
    end

    // Next-state logic; only the owner's response handshake can release RESP.
    always_comb begin
        state_s       = state_r;
        owner_ready_s = owner_r ? rsp1_ready_i : rsp0_ready_i;
        case (state_r)
            IDLE: begin
                if (grant_s) begin
                    state_s = EXEC;
                end else begin
                    state_s = IDLE;
                end
            end
            EXEC: begin
                state_s = RESP;
            end
            RESP: begin
                if (owner_ready_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, payload latch and result capture. The ALU drive registers are
    // non-zero only during EXEC, so they can feed the ALU ports directly.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r      <= IDLE;
            owner_r      <= 1'b0;
            last_grant_r <= 1'b1;
            ctrl_r       <= 4'd0;
            op1_r        <= 32'd0;
            op2_r        <= 32'd0;
            result0_r    <= 32'd0;
            result1_r    <= 32'd0;
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
        end else begin
            state_r <= state_s;
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        owner_r      <= grant_id_s;
                        last_grant_r <= grant_id_s;
                        ctrl_r       <= grant_id_s ? req1_ctrl_i : req0_ctrl_i;
                        op1_r        <= grant_id_s ? req1_op1_i  : req0_op1_i;
                        op2_r        <= grant_id_s ? req1_op2_i  : req0_op2_i;
                    end
                end
                EXEC: begin
                    ctrl_r <= 4'd0;
                    op1_r  <= 32'd0;
                    op2_r  <= 32'd0;
                    if (owner_r) begin
                        result1_r    <= alu_result_i;
                        rsp1_valid_r <= 1'b1;
                    end else begin
                        result0_r    <= alu_result_i;
                        rsp0_valid_r <= 1'b1;
                    end
                end
                RESP: begin
                    if (owner_ready_s) begin
                        rsp0_valid_r <= 1'b0;
                        rsp1_valid_r <= 1'b0;
                    end
                end
                default: begin
                    rsp0_valid_r <= 1'b0;
                    rsp1_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign req0_ready_o  = grant_s & ~grant_id_s;
    assign req1_ready_o  = grant_s &  grant_id_s;
    assign rsp0_valid_o  = rsp0_valid_r;
    assign rsp1_valid_o  = rsp1_valid_r;
    assign rsp0_result_o = result0_r;
    assign rsp1_result_o = result1_r;
    assign alu_ctrl_o    = ctrl_r;
    assign alu_op1_o     = op1_r;
    assign alu_op2_o     = op2_r;

endmodule

// File: tb/tb_toast_alu_arbiter.sv
// Directed bench for toast_alu_arbiter: round-robin and fixed-priority instances share
// the request stimulus; each drives its own behavioural ALU stub.
module tb_toast_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v0 = 1'b0, v1 = 1'b0, rr0 = 1'b0, rr1 = 1'b0;
    logic [3:0]  c0 = 4'd0, c1 = 4'd0;
    logic [31:0] a0 = 32'd0, b0 = 32'd0, a1 = 32'd0, b1 = 32'd0;

    logic        m_ready0, m_ready1, m_rsp0_valid, m_rsp1_valid;
    logic [31:0] m_rsp0_result, m_rsp1_result, m_alu_op1, m_alu_op2, m_alu_result;
    logic [3:0]  m_alu_ctrl;
    logic        f_ready0, f_ready1, f_rsp0_valid, f_rsp1_valid;
    logic [31:0] f_rsp0_result, f_rsp1_result, f_alu_op1, f_alu_op2, f_alu_result;
    logic [3:0]  f_alu_ctrl;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'd0:    alu_f = a + b;
            4'd1:    alu_f = a - b;
            4'd2:    alu_f = a & b;
            4'd3:    alu_f = a | b;
            4'd4:    alu_f = a ^ b;
            4'd5:    alu_f = a << b[4:0];
            4'd6:    alu_f = a >> b[4:0];
            4'd7:    alu_f = $signed(a) >>> b[4:0];
            4'd8:    alu_f = {31'd0, $signed(a) < $signed(b)};
            4'd9:    alu_f = {31'd0, a < b};
            4'd10:   alu_f = b;
            default: alu_f = 32'd0;
        endcase
    endfunction

    assign m_alu_result = alu_f(m_alu_ctrl, m_alu_op1, m_alu_op2);
    assign f_alu_result = alu_f(f_alu_ctrl, f_alu_op1, f_alu_op2);

    toast_alu_arbiter #(.FIXED_PRI(1'b0)) dut (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(v0), .req0_ready_o(m_ready0), .req0_ctrl_i(c0), .req0_op1_i(a0), .req0_op2_i(b0),
        .rsp0_valid_o(m_rsp0_valid), .rsp0_ready_i(rr0), .rsp0_result_o(m_rsp0_result),
        .req1_valid_i(v1), .req1_ready_o(m_ready1), .req1_ctrl_i(c1), .req1_op1_i(a1), .req1_op2_i(b1),
        .rsp1_valid_o(m_rsp1_valid), .rsp1_ready_i(rr1), .rsp1_result_o(m_rsp1_result),
        .alu_ctrl_o(m_alu_ctrl), .alu_op1_o(m_alu_op1), .alu_op2_o(m_alu_op2), .alu_result_i(m_alu_result)
    );

    toast_alu_arbiter #(.FIXED_PRI(1'b1)) dut_fp (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(v0), .req0_ready_o(f_ready0), .req0_ctrl_i(c0), .req0_op1_i(a0), .req0_op2_i(b0),
        .rsp0_valid_o(f_rsp0_valid), .rsp0_ready_i(rr0), .rsp0_result_o(f_rsp0_result),
        .req1_valid_i(v1), .req1_ready_o(f_ready1), .req1_ctrl_i(c1), .req1_op1_i(a1), .req1_op2_i(b1),
        .rsp1_valid_o(f_rsp1_valid), .rsp1_ready_i(rr1), .rsp1_result_o(f_rsp1_result),
        .alu_ctrl_o(f_alu_ctrl), .alu_op1_o(f_alu_op1), .alu_op2_o(f_alu_op2), .alu_result_i(f_alu_result)
    );

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        v0 = 1'b0; v1 = 1'b0; rr0 = 1'b0; rr1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        #1;
        checks++;
        if ({m_ready0, m_ready1, m_rsp0_valid, m_rsp1_valid} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got %b exp 0000", {m_ready0, m_ready1, m_rsp0_valid, m_rsp1_valid});
        end
        checks++;
        if ({m_rsp0_result, m_rsp1_result} !== 64'd0) begin
            errors++; $display("FAIL reset_results got %h %h exp 0", m_rsp0_result, m_rsp1_result);
        end
        checks++;
        if ({m_alu_ctrl, m_alu_op1, m_alu_op2} !== 68'd0) begin
            errors++; $display("FAIL reset_alu got %h %h %h exp 0", m_alu_ctrl, m_alu_op1, m_alu_op2);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        do_reset();
        v0 = 1'b1; c0 = 4'd0; a0 = 32'd5;  b0 = 32'd7;
        v1 = 1'b1; c1 = 4'd1; a1 = 32'd10; b1 = 32'd3;
        rr0 = 1'b1; rr1 = 1'b1;
        #1;
        checks++;
        if ({m_ready0, m_ready1} !== 2'b10) begin
            errors++; $display("FAIL basic_first_grant got %b exp 10", {m_ready0, m_ready1});
        end
        step(); v0 = 1'b0; #1;
        checks++;
        if ({m_ready1, m_alu_op1, m_alu_op2} !== {1'b0, 32'd5, 32'd7}) begin
            errors++; $display("FAIL basic_exec got rdy1=%b op1=%0d op2=%0d exp 0 5 7", m_ready1, m_alu_op1, m_alu_op2);
        end
        step(); #1;
        checks++;
        if ({m_rsp0_valid, m_rsp1_valid, m_rsp0_result} !== {2'b10, 32'd12}) begin
            errors++; $display("FAIL basic_rsp0 got v=%b%b res=%0d exp 10 12", m_rsp0_valid, m_rsp1_valid, m_rsp0_result);
        end
        step(); #1;
        checks++;
        if ({m_ready0, m_ready1} !== 2'b01) begin
            errors++; $display("FAIL basic_second_grant got %b exp 01", {m_ready0, m_ready1});
        end
        step(); v1 = 1'b0; #1;
        checks++;
        if (m_alu_ctrl !== 4'd1) begin
            errors++; $display("FAIL basic_exec_ctrl got %0d exp 1", m_alu_ctrl);
        end
        step(); #1;
        checks++;
        if ({m_rsp1_valid, m_rsp0_valid, m_rsp1_result} !== {2'b10, 32'd7}) begin
            errors++; $display("FAIL basic_rsp1 got v=%b%b res=%0d exp 10 7", m_rsp1_valid, m_rsp0_valid, m_rsp1_result);
        end
        step(); #1;
        checks++;
        if ({m_rsp1_valid, m_rsp0_result, m_rsp1_result} !== {1'b0, 32'd12, 32'd7}) begin
            errors++; $display("FAIL basic_retain got v=%b r0=%0d r1=%0d exp 0 12 7", m_rsp1_valid, m_rsp0_result, m_rsp1_result);
        end
    endtask

    task automatic test_alternate;
        logic m_g[$];
        logic f_g[$];
        do_reset();
        v0 = 1'b1; c0 = 4'd0; a0 = 32'd1; b0 = 32'd1;
        v1 = 1'b1; c1 = 4'd0; a1 = 32'd2; b1 = 32'd2;
        rr0 = 1'b1; rr1 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (m_ready0 || m_ready1) m_g.push_back(m_ready1);
            if (f_ready0 || f_ready1) f_g.push_back(f_ready1);
            step();
        end
        v0 = 1'b0; v1 = 1'b0;
        checks++;
        if (m_g.size() !== 4 || f_g.size() !== 4) begin
            errors++; $display("FAIL alt_count got rr=%0d fp=%0d exp 4 4", m_g.size(), f_g.size());
        end
        for (int i = 0; i < m_g.size(); i++) begin
            checks++;
            if (m_g[i] !== i[0]) begin
                errors++; $display("FAIL alt_rr_grant[%0d] got %b exp %b", i, m_g[i], i[0]);
            end
        end
        for (int i = 0; i < f_g.size(); i++) begin
            checks++;
            if (f_g[i] !== 1'b0) begin
                errors++; $display("FAIL alt_fp_grant[%0d] got %b exp 0", i, f_g[i]);
            end
        end
        step(); step(); step();
    endtask

    task automatic test_backpressure;
        do_reset();
        v1 = 1'b1; c1 = 4'd8; a1 = 32'hFFFF_FFFF; b1 = 32'd1;
        rr1 = 1'b0; rr0 = 1'b1;
        #1;
        checks++;
        if (m_ready1 !== 1'b1) begin
            errors++; $display("FAIL bp_grant1 got %b exp 1", m_ready1);
        end
        step(); v1 = 1'b0; v0 = 1'b1; c0 = 4'd0; a0 = 32'd3; b0 = 32'd4; #1;
        checks++;
        if (m_ready0 !== 1'b0) begin
            errors++; $display("FAIL bp_exec_ready0 got %b exp 0", m_ready0);
        end
        step();
        for (int k = 0; k < 10; k++) begin
            #1;
            checks++;
            if ({m_rsp1_valid, m_rsp1_result, m_ready0, m_rsp0_valid} !== {1'b1, 32'd1, 2'b00}) begin
                errors++; $display("FAIL bp_hold[%0d] got v1=%b res=%0d rdy0=%b v0=%b exp 1 1 0 0",
                                   k, m_rsp1_valid, m_rsp1_result, m_ready0, m_rsp0_valid);
            end
            step();
        end
        rr1 = 1'b1; #1;
        checks++;
        if (m_ready0 !== 1'b0) begin
            errors++; $display("FAIL bp_release_cycle got %b exp 0", m_ready0);
        end
        step(); #1;
        checks++;
        if ({m_ready0, m_rsp1_valid} !== 2'b10) begin
            errors++; $display("FAIL bp_after_release got rdy0=%b v1=%b exp 1 0", m_ready0, m_rsp1_valid);
        end
        step(); v0 = 1'b0; rr1 = 1'b0;
        step(); step();
    endtask

    task automatic test_reset_mid;
        do_reset();
        v0 = 1'b1; c0 = 4'd0; a0 = 32'd20; b0 = 32'd22; rr0 = 1'b1;
        #1;
        checks++;
        if (m_ready0 !== 1'b1) begin
            errors++; $display("FAIL rmid_grant got %b exp 1", m_ready0);
        end
        step(); v0 = 1'b0; #1;
        rst = 1'b1; #1;
        checks++;
        if ({m_alu_ctrl, m_alu_op1, m_alu_op2, m_rsp0_valid} !== 69'd0) begin
            errors++; $display("FAIL rmid_async got op1=%0d op2=%0d v0=%b exp 0", m_alu_op1, m_alu_op2, m_rsp0_valid);
        end
        @(negedge clk); rst = 1'b0; #1;
        checks++;
        if ({m_rsp0_valid, m_rsp0_result, m_ready0, m_ready1} !== 35'd0) begin
            errors++; $display("FAIL rmid_after got v0=%b res=%0d exp 0 0", m_rsp0_valid, m_rsp0_result);
        end
        step(); #1;
        checks++;
        if (m_rsp0_valid !== 1'b0) begin
            errors++; $display("FAIL rmid_no_rsp got %b exp 0", m_rsp0_valid);
        end
        v0 = 1'b1; v1 = 1'b1; c1 = 4'd0; a1 = 32'd1; b1 = 32'd1; #1;
        checks++;
        if ({m_ready0, m_ready1} !== 2'b10) begin
            errors++; $display("FAIL rmid_tie got %b exp 10", {m_ready0, m_ready1});
        end
        step(); v0 = 1'b0; v1 = 1'b0;
        step(); step();
    endtask

    task automatic test_cancel;
        do_reset();
        v1 = 1'b1; c1 = 4'd2; a1 = 32'h0000_00F0; b1 = 32'h0000_003C; rr1 = 1'b0;
        #1;
        checks++;
        if (m_ready1 !== 1'b1) begin
            errors++; $display("FAIL cancel_grant1 got %b exp 1", m_ready1);
        end
        step(); v1 = 1'b0; v0 = 1'b1; c0 = 4'd0; a0 = 32'd1; b0 = 32'd1; #1;
        checks++;
        if (m_ready0 !== 1'b0) begin
            errors++; $display("FAIL cancel_ready0 got %b exp 0", m_ready0);
        end
        step(); v0 = 1'b0; #1;
        checks++;
        if ({m_rsp1_valid, m_rsp1_result, m_rsp0_valid} !== {1'b1, 32'h30, 1'b0}) begin
            errors++; $display("FAIL cancel_rsp1 got v1=%b res=%h v0=%b exp 1 30 0", m_rsp1_valid, m_rsp1_result, m_rsp0_valid);
        end
        rr1 = 1'b1;
        step(); rr1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if ({m_ready0, m_rsp0_valid, m_alu_op1} !== 34'd0) begin
                errors++; $display("FAIL cancel_idle[%0d] got rdy0=%b v0=%b op1=%0d exp 0", k, m_ready0, m_rsp0_valid, m_alu_op1);
            end
            step();
        end
    endtask

    task automatic set_req(input bit r, input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        if (r) begin
            v1 = v; c1 = c; a1 = a; b1 = b;
        end else begin
            v0 = v; c0 = c; a0 = a; b0 = b;
        end
    endtask

    task automatic test_random;
        bit          r;
        int          d;
        logic [3:0]  c;
        logic [31:0] a, b, exp_res;
        do_reset();
        for (int i = 0; i < 22; i++) begin
            r = 1'($urandom_range(0, 1));
            c = 4'(i % 11);
            a = $urandom;
            b = $urandom;
            d = $urandom_range(0, 3);
            exp_res = alu_f(c, a, b);
            set_req(r, 1'b1, c, a, b);
            #1;
            checks++;
            if ((r ? m_ready1 : m_ready0) !== 1'b1) begin
                errors++; $display("FAIL rnd_grant[%0d] req%0d got 0 exp 1", i, r);
            end
            step();
            set_req(r, 1'b0, c, a, b);
            set_req(!r, 1'b1, 4'd0, 32'd0, 32'd0);
            for (int k = 0; k <= d + 1; k++) begin
                #1;
                checks++;
                if ((r ? m_ready0 : m_ready1) !== 1'b0) begin
                    errors++; $display("FAIL rnd_busy_grant[%0d] cycle %0d got 1 exp 0", i, k);
                end
                if (k > 0) begin
                    checks++;
                    if ((r ? {m_rsp1_valid, m_rsp1_result} : {m_rsp0_valid, m_rsp0_result}) !== {1'b1, exp_res}) begin
                        errors++; $display("FAIL rnd_rsp[%0d] op %0d got %h exp %h", i, c,
                                           r ? m_rsp1_result : m_rsp0_result, exp_res);
                    end
                end
                if (k == d + 1) begin
                    if (r) rr1 = 1'b1; else rr0 = 1'b1;
                    set_req(!r, 1'b0, 4'd0, 32'd0, 32'd0);
                end
                step();
            end
            rr0 = 1'b0; rr1 = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_alternate();
        test_backpressure();
        test_reset_mid();
        test_cancel();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
